// File: rtl/lut_neuron_pkg.sv
// Shared types and helpers for the programmable LUT neuron.
package lut_neuron_pkg;

  typedef enum logic {
    INIT = 1'b0,
    RUN  = 1'b1
  } lut_state_e;

  localparam int LUT_MAX_ADDR_W = 12;

  function automatic int lut_addr_w(input int fanin, input int in_bits);
    return fanin * in_bits;
  endfunction

endpackage

// File: rtl/lut_neuron_ram.sv
// Distributed truth-table RAM: synchronous write, asynchronous read.
// Reads see the pre-edge contents, so same-cycle read/write is read-first.
module lut_neuron_ram #(
  parameter  int ADDR_W = 8,
  parameter  int DATA_W = 2,
  localparam int DEPTH  = 1 << ADDR_W
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [ADDR_W-1:0] raddr,
  output logic [DATA_W-1:0] rdata
);

  (* ram_style = "distributed" *) logic [DATA_W-1:0] mem_q [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      mem_q[waddr] <= wdata;
    end
  end

  assign rdata = mem_q[raddr];

endmodule

// File: rtl/lut_neuron_prog.sv
// Runtime-programmable LUT neuron with init sweep and one-deep output register.
// Optional per-entry even parity with sticky error flag: define LUT_NEURON_PARITY_EN.
module lut_neuron_prog
  import lut_neuron_pkg::*;
#(
  parameter  int                  FANIN    = 4,
  parameter  int                  IN_BITS  = 2,
  parameter  int                  OUT_BITS = 2,
  parameter  logic [OUT_BITS-1:0] INIT_VAL = '0,
  localparam int                  ADDR_W   = lut_addr_w(FANIN, IN_BITS),
  localparam int                  DEPTH    = 1 << ADDR_W
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [ADDR_W-1:0]   in_data,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [OUT_BITS-1:0] out_data,
  input  logic                cfg_we,
  input  logic [ADDR_W-1:0]   cfg_addr,
  input  logic [OUT_BITS-1:0] cfg_data,
  output logic                cfg_ready,
  output logic                busy,
  output logic                par_err
);

  if (ADDR_W < 1 || ADDR_W > LUT_MAX_ADDR_W) begin : g_bad_addr_w
    $error("lut_neuron_prog: FANIN*IN_BITS must lie in 1..12");
  end

`ifdef LUT_NEURON_PARITY_EN
  localparam int DATA_W = OUT_BITS + 1;
`else
  localparam int DATA_W = OUT_BITS;
`endif
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

  lut_state_e          state_q, state_d;
  logic [ADDR_W-1:0]   cnt_q, cnt_d;
  logic                out_valid_q, out_valid_d;
  logic [OUT_BITS-1:0] out_data_q, out_data_d;
  logic                in_init, fire, wr_en;
  logic [ADDR_W-1:0]   wr_addr;
  logic [OUT_BITS-1:0] wr_data;
  logic [DATA_W-1:0]   ram_wdata, ram_rdata;

  assign in_init   = (state_q == INIT);
  assign in_ready  = !in_init && (!out_valid_q || out_ready);
  assign cfg_ready = !in_init;
  assign busy      = in_init;
  assign fire      = in_valid && in_ready;
  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;

  // The sweep owns the write port during INIT, so configuration writes are dropped.
  assign wr_en   = in_init || cfg_we;
  assign wr_addr = in_init ? cnt_q : cfg_addr;
  assign wr_data = in_init ? INIT_VAL : cfg_data;

`ifdef LUT_NEURON_PARITY_EN
  logic par_err_q;

  assign ram_wdata = {^wr_data, wr_data};
  assign par_err   = par_err_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      par_err_q <= 1'b0;
    end else if (fire && (^ram_rdata)) begin
      par_err_q <= 1'b1;
    end
  end
`else
  assign ram_wdata = wr_data;
  assign par_err   = 1'b0;
`endif

  lut_neuron_ram #(
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W)
  ) u_ram (
    .clk   (clk),
    .we    (wr_en),
    .waddr (wr_addr),
    .wdata (ram_wdata),
    .raddr (in_data),
    .rdata (ram_rdata)
  );

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    if (in_init) begin
      if (cnt_q == LAST_ADDR) begin
        state_d = RUN;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
    if (fire) begin
      out_valid_d = 1'b1;
      out_data_d  = ram_rdata[OUT_BITS-1:0];
    end else if (out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= INIT;
      cnt_q       <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
    end
  end

endmodule

// File: tb/tb_lut_neuron_prog.sv
// Self-checking bench for lut_neuron_prog: table/queue reference model plus directed literals.
module tb_lut_neuron_prog;

  localparam int         AW       = 8;
  localparam int         DEPTH    = 256;
  localparam logic [1:0] INIT_VAL = 2'b00;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [AW-1:0] in_data = '0;
  logic          out_valid;
  logic          out_ready = 1'b0;
  logic [1:0]    out_data;
  logic          cfg_we = 1'b0;
  logic [AW-1:0] cfg_addr = '0;
  logic [1:0]    cfg_data = '0;
  logic          cfg_ready;
  logic          busy;
  logic          par_err;

  int tests = 0;
  int fails = 0;

  lut_neuron_prog #(
    .FANIN    (4),
    .IN_BITS  (2),
    .OUT_BITS (2),
    .INIT_VAL (INIT_VAL)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .cfg_we    (cfg_we),
    .cfg_addr  (cfg_addr),
    .cfg_data  (cfg_data),
    .cfg_ready (cfg_ready),
    .busy      (busy),
    .par_err   (par_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: table contents, pending-result queue, edges since reset release.
  logic [1:0] mdl_mem [DEPTH];
  logic [1:0] mdl_q [$];
  bit         mdl_corrupt [DEPTH];
  bit         mdl_par_err = 1'b0;
  int         run_cnt = 0;

  always @(negedge clk) begin
    bit run;
    bit exp_rdy;
    bit accept;
    logic [1:0] rd;
    if (rst) begin
      check("rst_out_valid", out_valid, 0);
      check("rst_out_data", out_data, 0);
      check("rst_in_ready", in_ready, 0);
      check("rst_cfg_ready", cfg_ready, 0);
      check("rst_busy", busy, 1);
      check("rst_par_err", par_err, 0);
      mdl_q.delete();
      run_cnt = 0;
      mdl_par_err = 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
        mdl_mem[i] = INIT_VAL;
        mdl_corrupt[i] = 1'b0;
      end
    end else begin
      run     = (run_cnt >= DEPTH);
      exp_rdy = run && (mdl_q.size() == 0 || out_ready);
      check("busy", busy, {31'd0, !run});
      check("cfg_ready", cfg_ready, {31'd0, run});
      check("in_ready", in_ready, {31'd0, exp_rdy});
      check("out_valid", out_valid, {31'd0, mdl_q.size() != 0});
      if (mdl_q.size() != 0) check("out_data", out_data, mdl_q[0]);
      check("par_err", par_err, {31'd0, mdl_par_err});
      accept = in_valid && exp_rdy;
      rd = mdl_mem[in_data];
      if (mdl_q.size() != 0 && out_ready) void'(mdl_q.pop_front());
      if (accept) begin
        mdl_q.push_back(rd);
        if (mdl_corrupt[in_data]) mdl_par_err = 1'b1;
      end
      if (run && cfg_we) begin
        mdl_mem[cfg_addr] = cfg_data;
        mdl_corrupt[cfg_addr] = 1'b0;
      end
      if (run_cnt < DEPTH) run_cnt++;
    end
  end

  logic [AW-1:0] addr_tab [8];
  logic [1:0]    res [8];
  logic          res_v [8];
  logic          res_pe [8];

  // Called at posedge+1; feeds n back-to-back lookups and captures each result.
  task automatic stream(input int n);
    for (int i = 0; i <= n; i++) begin
      if (i < n) begin
        in_valid = 1'b1;
        in_data  = addr_tab[i];
      end else begin
        in_valid = 1'b0;
      end
      @(negedge clk);
      if (i > 0) begin
        res_v[i-1]  = out_valid;
        res[i-1]    = out_data;
        res_pe[i-1] = par_err;
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic cfg_write(input logic [AW-1:0] a, input logic [1:0] d);
    cfg_we = 1'b1;
    cfg_addr = a;
    cfg_data = d;
    @(posedge clk); #1;
    cfg_we = 1'b0;
  endtask

  task automatic wait_run(input string name);
    int first;
    first = -1;
    for (int n = 0; n < DEPTH + 20; n++) begin
      @(negedge clk);
      if (in_ready) begin
        first = n;
        break;
      end
    end
    check(name, first, DEPTH);
    @(posedge clk); #1;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    wait_run("in_ready_first_cycle");
    out_ready = 1'b1;

    addr_tab[0] = 8'h00;
    stream(1);
    check("lookup00_valid", res_v[0], 1);
    check("lookup00_data", res[0], 2'b00);

    cfg_write(8'h10, 2'b01);
    cfg_write(8'h40, 2'b11);
    addr_tab[0] = 8'h10; addr_tab[1] = 8'h40; addr_tab[2] = 8'h41;
    stream(3);
    check("s0_valid", res_v[0], 1);
    check("s0_data", res[0], 2'b01);
    check("s1_valid", res_v[1], 1);
    check("s1_data", res[1], 2'b11);
    check("s2_valid", res_v[2], 1);
    check("s2_data", res[2], 2'b00);

    // Backpressure: result 0x40 stalls while 0x10 waits at the input.
    out_ready = 1'b0;
    in_valid = 1'b1;
    in_data = 8'h40;
    @(posedge clk); #1;
    in_data = 8'h10;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("bp_valid", out_valid, 1);
      check("bp_in_ready", in_ready, 0);
      check("bp_data", out_data, 2'b11);
    end
    @(posedge clk); #1;
    out_ready = 1'b1;
    @(negedge clk);
    check("bp_rel_data", out_data, 2'b11);
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(negedge clk);
    check("bp_next_valid", out_valid, 1);
    check("bp_next_data", out_data, 2'b01);
    @(posedge clk); #1;
    @(negedge clk);
    check("bp_drain_valid", out_valid, 0);
    @(posedge clk); #1;

    // Same-edge write and lookup of 0x20: read-first.
    cfg_we = 1'b1; cfg_addr = 8'h20; cfg_data = 2'b10;
    addr_tab[0] = 8'h20;
    stream(1);
    cfg_we = 1'b0;
    check("rw_old", res[0], 2'b00);
    stream(1);
    check("rw_new", res[0], 2'b10);

    for (int c = 0; c < 3000; c++) begin
      in_valid  = ($urandom_range(0, 3) != 0);
      in_data   = ($urandom_range(0, 3) == 0) ? AW'($urandom) : AW'($urandom_range(0, 15));
      out_ready = ($urandom_range(0, 3) != 0);
      cfg_we    = ($urandom_range(0, 3) == 0);
      cfg_addr  = ($urandom_range(0, 3) == 0) ? AW'($urandom) : AW'($urandom_range(0, 15));
      cfg_data  = 2'($urandom);
      @(posedge clk); #1;
    end
    in_valid = 1'b0; cfg_we = 1'b0; out_ready = 1'b1;
    cfg_write(8'h10, 2'b01);
    repeat (2) @(posedge clk);
    #1;

    // Asynchronous reset with a result pending.
    out_ready = 1'b0;
    in_valid = 1'b1;
    in_data = 8'h10;
    @(posedge clk); #1;
    in_valid = 1'b0;
    check("pre_rst_valid", out_valid, 1);
    #2 rst = 1'b1;
    #1 check("async_clear_valid", out_valid, 0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    out_ready = 1'b1;
    wait_run("in_ready_after_rst");
    addr_tab[0] = 8'h10;
    stream(1);
    check("post_rst_valid", res_v[0], 1);
    check("post_rst_data", res[0], INIT_VAL);

`ifdef LUT_NEURON_PARITY_EN
    dut.u_ram.mem_q[16][2] = ~dut.u_ram.mem_q[16][2];
    mdl_corrupt[16] = 1'b1;
    addr_tab[0] = 8'h10;
    stream(1);
    check("par_data_unchanged", res[0], INIT_VAL);
    check("par_err_rise", res_pe[0], 1);
    repeat (3) @(posedge clk);
    #1 check("par_err_sticky", par_err, 1);
    rst = 1'b1;
    #1 check("par_err_rst", par_err, 0);
    @(posedge clk); #1 rst = 1'b0;
`endif

    repeat (3) @(posedge clk);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/lut_neuron_prog.md
# lut_neuron_prog

Runtime-programmable, pipelined LUT neuron for the LogicNets datapath. It generalises the fixed-ROM neuron: fan-in, input bit-width and output bit-width are parameters, and the truth table lives in a writable distributed RAM instead of a synthesised case statement. A valid/ready stream sits on each side. Instances sit between layer register stages, so retrained tables can be loaded without resynthesis.

## Interface
- `FANIN`, default 4: number of quantised inputs.
- `IN_BITS`, default 2: bits per input.
- `OUT_BITS`, default 2: output bits.
- `ADDR_W`, derived as FANIN*IN_BITS: table address width. Legal range 1..12; elaboration error outside it.
- `DEPTH`, derived as 2**ADDR_W: table entries.
- `INIT_VAL`, default 0: value written to every entry during the init sweep.
- `clk`, in, 1: single clock; all logic on its rising edge.
- `rst`, in, 1: asynchronous, active-high reset.
- `in_valid`, in, 1: input sample valid.
- `in_ready`, out, 1: block accepts a sample.
- `in_data`, in, ADDR_W: concatenated inputs; input k occupies bits [k*IN_BITS +: IN_BITS]. Used directly as the table index.
- `out_valid`, out, 1: result valid.
- `out_ready`, in, 1: downstream accepts the result.
- `out_data`, out, OUT_BITS: table[in_data].
- `cfg_we`, in, 1: table write strobe.
- `cfg_addr`, in, ADDR_W: write address.
- `cfg_data`, in, OUT_BITS: write data.
- `cfg_ready`, out, 1: high when writes are accepted (RUN state).
- `busy`, out, 1: high during the init sweep.

## Operation
- FSM states: INIT and RUN.
  - Reset forces INIT, with sweep counter = 0.
  - INIT writes INIT_VAL at address counter and increments the counter once per cycle.
  - After writing DEPTH-1, the FSM moves to RUN; the counter is not wrapped further.
- Behaviour during INIT:
  - `in_ready`=0, `cfg_ready`=0, `busy`=1.
  - `cfg_we` is ignored and the write is dropped.
- Behaviour in RUN:
  - `cfg_we`=1 writes `cfg_data` to `cfg_addr` at the clock edge.
  - A lookup fires when `in_valid && in_ready`; the table is read combinationally and the result is captured in the output register.
- Output stage: single register with stall logic.
  - `in_ready` = RUN && (!out_valid || out_ready).
  - On a lookup, `out_valid` is set to 1 and `out_data` loads the table value.
  - When the output is taken (`out_valid && out_ready`) with no new lookup, `out_valid` clears to 0.
  - While `out_valid` is high and `out_ready` is low, `out_data` holds stable.
- Same-cycle lookup and write to the same address: the lookup returns the OLD entry (read-first); the new value is visible from the next cycle.
- Width rules:
  - No arithmetic on data; the index is `in_data` unmodified.
  - `cfg_data` is stored exactly OUT_BITS wide.

## Timing
- Reset values:
  - `out_valid`=0, `out_data`=0, `in_ready`=0, `cfg_ready`=0, `busy`=1.
  - Parity error flag = 0.
- Init sweep takes DEPTH cycles after reset deassertion. `in_ready` first rises at cycle DEPTH (counting from the first edge after reset is released).
- Lookup latency: 1 cycle, from the accepting edge to `out_valid` high.
- Throughput: 1 sample/cycle while `out_ready`=1.
- Reset asserted mid-operation:
  - Any in-flight output is discarded immediately (asynchronous clear).
  - The table is re-initialised by a full INIT sweep.
- `out_valid` never deasserts without a handshake, except on reset.

## Configuration
- `LUT_NEURON_PARITY_EN` defined:
  - Each entry stores OUT_BITS+1 bits, where the extra bit is even parity of the data. It is computed on every write, including INIT writes.
  - Every lookup rechecks parity. On a mismatch, `par_err` (out, 1) sets sticky high on the same edge that loads `out_data`; it is cleared only by `rst`.
  - Output data is delivered unchanged on a mismatch.
- Macro undefined: no parity bit is stored; `par_err` is tied to 0 and the port still exists.

## Structure
- Shared package `lut_neuron_pkg`:
  - FSM state enum `lut_state_e` {INIT, RUN}.
  - Function `lut_addr_w(fanin, in_bits)`.
  - Constant `LUT_MAX_ADDR_W`=12.
- One sub-module, `lut_neuron_ram`: distributed RAM with one synchronous write port and one asynchronous read port, marked for distributed ROM/RAM style. The top level holds the FSM, the output register and the parity logic.

## Test plan
- Reset release, then idle for 256 cycles (defaults): `busy`=1 and `in_ready`=0 for cycles 0..255; `busy`=0 and `in_ready`=1 at cycle 256; lookup of 8'h00 returns 2'b00.
- Program address 8'h10 = 2'b01 and 8'h40 = 2'b11, then stream 8'h10, 8'h40, 8'h41 back-to-back: outputs 01, 11, 00 on consecutive cycles, each 1 cycle after acceptance.
- Backpressure: hold `out_ready`=0 for 5 cycles with an output pending: `in_ready`=0 and `out_data` held stable; release → exactly one handshake, no loss or duplication.
- Same-cycle write of 2'b10 to 8'h20 while looking up 8'h20 (old value 00): result is 00; the next lookup returns 10.
- Assert `rst` mid-stream with `out_valid`=1: `out_valid` drops without a clock edge; after the sweep, 8'h10 reads INIT_VAL.
- With `LUT_NEURON_PARITY_EN`: force-flip a stored bit at 8'h10, then look it up → `par_err` rises on the result edge, stays high, and clears only on `rst`.
